demux_word_collector: RTL and testbench
=======================================

Name: demux_word_collector

Overview:
- Downstream stage of the 1-to-4 bit demultiplexer.
- Each strobed cycle it takes the bit routed onto y0..y3 by select pair {s0,s1} and shifts it into that channel's word assembler.
- Completed words are buffered per channel, then drained through a single valid/ready output port with round-robin arbitration.
- The block turns four interleaved serial channels into tagged parallel words.

Parameters:
- WIDTH, 8, bits per assembled word (2..32); bit counter width = clog2(WIDTH).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- bit_vld  input  1  demux outputs hold a valid bit this cycle.
- s0  input  1  select MSB; same value that drives the demux.
- s1  input  1  select LSB; same value that drives the demux.
- y0  input  1  demux output, channel 0 ({s0,s1}=00).
- y1  input  1  demux output, channel 1 ({s0,s1}=01).
- y2  input  1  demux output, channel 2 ({s0,s1}=10).
- y3  input  1  demux output, channel 3 ({s0,s1}=11).
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  assembled word.
- out_chan  output  2  source channel of out_data.
- overflow  output  4  sticky per-channel word-dropped flag.

Behaviour:
- Reset (rst_n=0 at an edge), applied on every edge it is sampled:
  - All shift registers, bit counters, hold buffers and hold flags cleared.
  - out_valid=0, out_data=0, out_chan=0, overflow=4'b0.
  - Arbiter pointer cleared to 0.
  - A partially assembled word is discarded.
- Bit capture:
  - When bit_vld=1: c={s0,s1}, b=y_c; the other three y inputs are ignored.
  - sr[c] shifts LSB-first: sr[c] <= {b, sr[c][WIDTH-1:1]}; cnt[c] increments.
  - Channels not addressed keep their state, so interleaved channels assemble independently.
- Word completion: a bit captured with cnt[c]=WIDTH-1 completes the word {b, sr[c][WIDTH-1:1]}, and cnt[c] returns to 0.
  - If hold[c]=0, or hold[c] is drained into the output register on the same edge: word goes to hbuf[c] and hold[c]=1.
  - Otherwise the word is dropped, overflow[c] is set, and hbuf[c] is unchanged.
  - overflow bits clear only on reset.
- Output register:
  - Loads when out_valid=0 or out_ready=1, and at least one hold[c]=1.
  - Winner: first set hold flag scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On load: out_data=hbuf[win], out_chan=win, out_valid=1, hold[win]=0, ptr=win+1 (mod 4).
  - out_valid=1, out_ready=1, no hold set: out_valid drops to 0 next edge.
  - out_valid=1, out_ready=0: out_data/out_chan stable (valid/ready rule; never retracted).
- Latency: last bit sampled at edge k → hold set at edge k → out_valid=1 after edge k+1, if the output register is free.
- Throughput: one word per cycle out when out_ready stays 1.
- Storage: per channel, one assembling word + one held word; the output register adds one more word overall.
- bit_vld=0: no capture; the drain path keeps running.
- Simultaneous completion on channel c and drain of hold[c] on the same edge: no loss, no overflow.

Test Plan:
- Single word: reset, out_ready=1, {s0,s1}=10, y2 bits 1,0,1,0,0,1,0,1 on consecutive bit_vld cycles → out_valid high 2 cycles after last bit; out_data=8'hA5, out_chan=2; overflow=0.
- Interleave: alternate ch0 bits of 8'h3C with ch3 bits of 8'hF0, ch0 first, ready=1 → two words out: chan 0 data 8'h3C, then chan 3 data 8'hF0.
- Backpressure and overflow, out_ready=0, ch1 sent 8'h11, 8'h22, 8'h33:
  - Result: overflow=4'b0010.
  - Then ready=1 → exactly 8'h11 then 8'h22, both chan 1; 8'h33 never appears.
- Round robin, ready=0:
  - Complete words on ch0 (8'h01), ch1 (8'h02), ch3 (8'h04); the ch0 word occupies the output register.
  - Then send ch0 8'h05; ready=1.
  - Output order: 01, 02, 04, 05.
- Reset mid-operation: 5 bits into ch2, pulse rst_n=0 for one edge, then send a full 8'h5A on ch2 → single output 8'h5A, no leftover bits; stalled out_valid cleared by reset.
- Stability: out_valid=1 with ready=0 held 10 cycles while other channels complete words → out_data/out_chan unchanged throughout.

Source files
------------

// File: rtl/demux_word_collector.sv
// Collects the four serial channels of a 1-to-4 bit demultiplexer into parallel words,
// buffers one completed word per channel, and drains them round-robin through a valid/ready port.
module demux_word_collector #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_vld,
   input  logic             s0,
   input  logic             s1,
   input  logic             y0,
   input  logic             y1,
   input  logic             y2,
   input  logic             y3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_chan,
   output logic [3:0]       overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   // Per-channel assembly and hold storage
   logic [WIDTH-1:0] sr_reg   [4];
   logic [CW-1:0]    cnt_reg  [4];
   logic [WIDTH-1:0] hbuf_reg [4];
   logic [3:0]       hold_reg;
   logic [3:0]       overflow_reg;
   logic [1:0]       ptr_reg;

   // Output register
   logic             out_valid_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic [1:0]       out_chan_reg;

   // Capture decode
   logic [1:0]       cap_chan;
   logic             cap_bit;
   logic [3:0]       y_vec;
   logic [3:0]       cap_vec;
   logic [3:0]       done_vec;
   logic [WIDTH-1:0] word_arr [4];

   // Arbitration
   logic [1:0]       win;
   logic             found;
   logic             load;
   logic [3:0]       drain;
   logic [1:0]       idx;

   assign y_vec    = {y3, y2, y1, y0};
   assign cap_chan = {s0, s1};
   assign cap_bit  = y_vec[cap_chan];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_chan
         assign cap_vec[gi]  = bit_vld && (cap_chan == 2'(gi));
         assign done_vec[gi] = cap_vec[gi] && (cnt_reg[gi] == LAST_BIT);
         // LSB-first shift: the newest bit enters at the top
         assign word_arr[gi] = {cap_bit, sr_reg[gi][WIDTH-1:1]};
      end
   endgenerate

   // Round-robin winner: first held word at or after ptr_reg
   always_comb begin
      win   = ptr_reg;
      found = 1'b0;
      idx   = ptr_reg;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_reg + 2'(i);
         if (!found && hold_reg[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      load  = (!out_valid_reg || out_ready) && found;
      drain = 4'b0;
      if (load) begin
         drain[win] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            sr_reg[i]   <= '0;
            cnt_reg[i]  <= '0;
            hbuf_reg[i] <= '0;
         end
         hold_reg     <= 4'b0;
         overflow_reg <= 4'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (cap_vec[i]) begin
               sr_reg[i]  <= word_arr[i];
               cnt_reg[i] <= done_vec[i] ? '0 : cnt_reg[i] + 1'b1;
            end
            // A hold slot being drained this edge can accept the new word directly
            if (done_vec[i] && (!hold_reg[i] || drain[i])) begin
               hbuf_reg[i] <= word_arr[i];
               hold_reg[i] <= 1'b1;
            end else begin
               if (done_vec[i]) begin
                  overflow_reg[i] <= 1'b1;
               end
               if (drain[i]) begin
                  hold_reg[i] <= 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_chan_reg  <= 2'd0;
         ptr_reg       <= 2'd0;
      end else if (load) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= hbuf_reg[win];
         out_chan_reg  <= win;
         ptr_reg       <= win + 2'd1;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_chan  = out_chan_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_demux_word_collector.sv
// Scoreboard bench for demux_word_collector: directed words are queued as expected outputs,
// and a monitor checks every accepted word plus output stability while stalled.
module tb_demux_word_collector;

   logic       clk;
   logic       rst_n;
   logic       bit_vld;
   logic       s0, s1, y0, y1, y2, y3;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_chan;
   logic [3:0] overflow;

   int total = 0;
   int bad   = 0;
   logic [9:0] exp_q [$];

   logic       stall_prev = 1'b0;
   logic [9:0] stall_val  = '0;

   demux_word_collector #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld),
      .s0(s0), .s1(s1), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_chan(out_chan), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: inputs change just after posedge, so negedge sees what the next edge samples
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            total++;
            if (!out_valid || {out_chan, out_data} !== stall_val) begin
               bad++;
               $display("FAIL stall_stable: got valid=%0b chan=%0d data=%h want chan=%0d data=%h",
                        out_valid, out_chan, out_data, stall_val[9:8], stall_val[7:0]);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_word: got chan=%0d data=%h want no word", out_chan, out_data);
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               if ({out_chan, out_data} !== e) begin
                  bad++;
                  $display("FAIL word: got chan=%0d data=%h want chan=%0d data=%h",
                           out_chan, out_data, e[9:8], e[7:0]);
               end else begin
                  $display("word chan=%0d data=%h ok", out_chan, out_data);
               end
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_val  = {out_chan, out_data};
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end else begin
         $display("check %s = %0h ok", name, act);
      end
   endtask

   task automatic send_bit(input logic [1:0] c, input logic b);
      logic [3:0] yv;
      yv = {4{~b}};
      yv[c] = b;
      bit_vld = 1'b1;
      {s0, s1} = c;
      {y3, y2, y1, y0} = yv;
      cycle();
      bit_vld = 1'b0;
   endtask

   task automatic send_word(input logic [1:0] c, input logic [7:0] w);
      for (int i = 0; i < 8; i++) send_bit(c, w[i]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) cycle();
      check({name, "_drained"}, exp_q.size(), 0);
      for (int i = 0; i < 4; i++) cycle();
   endtask

   initial begin
      rst_n = 1'b0; bit_vld = 1'b0; out_ready = 1'b0;
      s0 = 1'b0; s1 = 1'b0; y0 = 1'b0; y1 = 1'b0; y2 = 1'b0; y3 = 1'b0;
      cycle(); cycle();
      rst_n = 1'b1;
      check("reset_valid", out_valid, 0);
      check("reset_data", out_data, 0);
      check("reset_chan", out_chan, 0);
      check("reset_overflow", overflow, 0);

      // Single word on ch2 with latency check
      out_ready = 1'b1;
      exp_q.push_back({2'd2, 8'hA5});
      send_word(2'd2, 8'hA5);
      check("single_valid_k", out_valid, 0);
      cycle();
      check("single_valid_k1", out_valid, 1);
      wait_drain("single");
      check("single_overflow", overflow, 0);

      // Interleaved ch0 / ch3
      exp_q.push_back({2'd0, 8'h3C});
      exp_q.push_back({2'd3, 8'hF0});
      for (int i = 0; i < 8; i++) begin
         logic [7:0] a, b;
         a = 8'h3C; b = 8'hF0;
         send_bit(2'd0, a[i]);
         send_bit(2'd3, b[i]);
      end
      wait_drain("interleave");

      // Backpressure and overflow on ch1
      do_reset();
      out_ready = 1'b0;
      exp_q.push_back({2'd1, 8'h11});
      exp_q.push_back({2'd1, 8'h22});
      send_word(2'd1, 8'h11);
      send_word(2'd1, 8'h22);
      send_word(2'd1, 8'h33);
      cycle();
      check("bp_overflow", overflow, 4'b0010);
      out_ready = 1'b1;
      wait_drain("bp");
      check("bp_overflow_sticky", overflow, 4'b0010);

      // Round robin
      do_reset();
      check("rr_overflow_cleared", overflow, 0);
      out_ready = 1'b0;
      exp_q.push_back({2'd0, 8'h01});
      exp_q.push_back({2'd1, 8'h02});
      exp_q.push_back({2'd3, 8'h04});
      exp_q.push_back({2'd0, 8'h05});
      send_word(2'd0, 8'h01);
      send_word(2'd1, 8'h02);
      send_word(2'd3, 8'h04);
      send_word(2'd0, 8'h05);
      cycle();
      out_ready = 1'b1;
      wait_drain("rr");
      check("rr_overflow", overflow, 0);

      // Reset mid-operation: stalled word and partial ch2 word are discarded
      out_ready = 1'b0;
      send_word(2'd1, 8'h77);
      cycle(); cycle();
      check("mid_stalled_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) send_bit(2'd2, 1'b1);
      do_reset();
      check("mid_valid_after_reset", out_valid, 0);
      check("mid_data_after_reset", out_data, 0);
      out_ready = 1'b1;
      exp_q.push_back({2'd2, 8'h5A});
      send_word(2'd2, 8'h5A);
      wait_drain("mid");

      // Stability while stalled and other channels complete
      out_ready = 1'b0;
      exp_q.push_back({2'd0, 8'hAB});
      exp_q.push_back({2'd1, 8'hCD});
      exp_q.push_back({2'd2, 8'hEF});
      send_word(2'd0, 8'hAB);
      send_word(2'd1, 8'hCD);
      send_word(2'd2, 8'hEF);
      check("stable_chan", out_chan, 0);
      check("stable_data", out_data, 8'hAB);
      out_ready = 1'b1;
      wait_drain("stable");
      check("stable_overflow", overflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
